// File: rtl/id_ex_skid_reg_if.sv
// Decode-to-execute handshake bundle: decode-side beat plus flush in, EX-side bundle out.
// slave = the pipeline register; master = the decode/EX environment that drives it.
interface id_ex_skid_reg_if #(
   parameter int DATA_W  = 32,
   parameter int RD_W    = 5,
   parameter int OP_W    = 4,
   parameter int SHAMT_W = 5
);
   logic                flush;

   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   in_pc;
   logic [DATA_W-1:0]   in_rs1;
   logic [DATA_W-1:0]   in_rs2;
   logic [DATA_W-1:0]   in_imm;
   logic [RD_W-1:0]     in_rd;
   logic [OP_W-1:0]     in_alu_op;
   logic                in_we;

   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   out_pc;
   logic [DATA_W-1:0]   out_rs1;
   logic [DATA_W-1:0]   out_rs2;
   logic [DATA_W-1:0]   out_imm;
   logic [SHAMT_W-1:0]  out_shamt;
   logic [RD_W-1:0]     out_rd;
   logic [OP_W-1:0]     out_alu_op;
   logic                out_we;

   modport slave (
      input  flush,
      input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_rd, in_alu_op, in_we,
      output in_ready,
      output out_valid, out_pc, out_rs1, out_rs2, out_imm, out_shamt, out_rd, out_alu_op, out_we,
      input  out_ready
   );

   modport master (
      output flush,
      output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_rd, in_alu_op, in_we,
      input  in_ready,
      input  out_valid, out_pc, out_rs1, out_rs2, out_imm, out_shamt, out_rd, out_alu_op, out_we,
      output out_ready
   );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID->EX two-entry skid register; a beat accepted at edge N is on the outputs from cycle N+1.
// in_ready is a flop (~skid_v), so out_ready stalls are absorbed by the skid entry at full rate.
module id_ex_skid_reg #(
   parameter int DATA_W  = 32,
   parameter int RD_W    = 5,
   parameter int OP_W    = 4,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   id_ex_skid_reg_if.slave   bus
);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rs1;
      logic [DATA_W-1:0] rs2;
      logic [DATA_W-1:0] imm;
      logic [RD_W-1:0]   rd;
      logic [OP_W-1:0]   alu_op;
      logic              we;
   } ent_t;

   ent_t  main_q;
   ent_t  skid_q;
   ent_t  in_ent;
   logic  main_v;
   logic  skid_v;

   logic  accept;
   logic  issue;
   logic  load_main_new;
   logic  load_main_skid;
   logic  load_skid;
   logic  main_v_n;
   logic  skid_v_n;

   assign in_ent = '{pc:     bus.in_pc,
                     rs1:    bus.in_rs1,
                     rs2:    bus.in_rs2,
                     imm:    bus.in_imm,
                     rd:     bus.in_rd,
                     alu_op: bus.in_alu_op,
                     we:     bus.in_we};

   assign accept = bus.in_valid & ~skid_v;
   assign issue  = main_v & bus.out_ready;

   // Flush suppresses every data load so a discarded beat never overwrites the held bundle.
   assign load_main_new  = ~bus.flush & accept & (~main_v | issue);
   assign load_main_skid = ~bus.flush & skid_v & issue;
   assign load_skid      = ~bus.flush & accept & main_v & ~issue;

   assign main_v_n = main_v ? (skid_v | accept | ~issue) : accept;
   assign skid_v_n = skid_v ? ~issue : load_skid;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (bus.flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else begin
         main_v <= main_v_n;
         skid_v <= skid_v_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
      end else if (load_main_skid) begin
         main_q <= skid_q;
      end else if (load_main_new) begin
         main_q <= in_ent;
      end
   end

   // Skid contents are only meaningful while skid_v is set, so no reset is needed.
   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_q <= in_ent;
      end
   end

   assign bus.in_ready   = ~skid_v;
   assign bus.out_valid  = main_v;
   assign bus.out_pc     = main_q.pc;
   assign bus.out_rs1    = main_q.rs1;
   assign bus.out_rs2    = main_q.rs2;
   assign bus.out_imm    = main_q.imm;
   assign bus.out_shamt  = main_q.imm[SHAMT_W-1:0];
   assign bus.out_rd     = main_q.rd;
   assign bus.out_alu_op = main_q.alu_op;
   assign bus.out_we     = main_q.we & main_v & (|main_q.rd);

   a_no_skid_without_main: assert property (@(posedge clk) disable iff (rst) !(skid_v && !main_v));

endmodule
